// File: rtl/i2c_slave_rx_if.sv
// i2c_slave_rx_if
// Bundles the pin-side I2C signals and the register-file write port of the
// I2C write responder.
//   scl_in, sda_in : raw (asynchronous) SCL/SDA pin levels
//   sda_oe         : 1 = pull SDA low (open-drain)
//   wr_strobe      : one-cycle pulse, wr_addr/wr_data valid
//   wr_addr        : {SubAddrH, SubAddrL}
//   wr_data        : received data byte
//   busy           : matched transaction in progress
//   errory         : one-cycle pulse on an aborted matched write
// Modport slave is used by the responder; master by whatever drives the bus.
interface i2c_slave_rx_if;
  logic        scl_in;
  logic        sda_in;
  logic        sda_oe;
  logic        wr_strobe;
  logic [15:0] wr_addr;
  logic [7:0]  wr_data;
  logic        busy;
  logic        errory;

  modport slave (
    input  scl_in, sda_in,
    output sda_oe, wr_strobe, wr_addr, wr_data, busy, errory
  );

  modport master (
    output scl_in, sda_in,
    input  sda_oe, wr_strobe, wr_addr, wr_data, busy, errory
  );
endinterface

// File: rtl/i2c_slave_rx.sv
// i2c_slave_rx
// I2C write responder. Oversamples SCL/SDA on I2C_clk, detects START/STOP,
// matches a 7-bit write address, receives SubAddrH, SubAddrL and Data bytes
// (ACKing each) and issues a one-cycle register-write strobe.
// Ports:
//   I2C_clk : sampling clock, >= 8x SCL
//   reset   : synchronous, active-high
//   bus     : i2c_slave_rx_if.slave (pins + register write port)
// Parameters: DEV_ADDR (7-bit target address), SYNC_STAGES (>= 2).
// Build option: define I2C_AUTOINC_EN to accept further data bytes after the
// first, with wr_addr incrementing by one (16-bit wrap) before each strobe.
// Without it, bytes after the first data byte are NACKed and ignored.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | bus free or after STOP
// ADDR     | receiving address + R/W byte
// ACK_ADDR | acknowledging matched address
// SUBH     | receiving sub-address high byte
// ACK_SUBH | acknowledging SubAddrH
// SUBL     | receiving sub-address low byte
// ACK_SUBL | acknowledging SubAddrL
// DATA     | receiving data byte
// ACK_DATA | acknowledging data byte (strobe already issued)
// IGNORE   | not addressed / no further bytes accepted; wait START/STOP
module i2c_slave_rx #(
  parameter logic [6:0] DEV_ADDR    = 7'h28,
  parameter int         SYNC_STAGES = 2
) (
  input  logic           I2C_clk,
  input  logic           reset,
  i2c_slave_rx_if.slave  bus
);

  typedef enum logic [3:0] {
    IDLE, ADDR, ACK_ADDR, SUBH, ACK_SUBH, SUBL, ACK_SUBL, DATA, ACK_DATA, IGNORE
  } state_t;

  state_t state, state_nxt;

  logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
  logic       scl_s, sda_s, scl_q, sda_q;
  logic       scl_rise, scl_fall, start, stop, abort;
  logic [2:0] bit_cnt;
  logic [7:0] shift;
  logic [7:0] byte_val;
  logic       rx_state, byte_done, addr_match;
  logic       ack_on;       // second half of the ACK slot: SDA is being held low
  logic       data_written; // a data byte has been strobed in this transaction

  assign scl_s = scl_sync[SYNC_STAGES-1];
  assign sda_s = sda_sync[SYNC_STAGES-1];

  assign scl_rise = scl_s & ~scl_q;
  assign scl_fall = ~scl_s & scl_q;
  assign start    = scl_s & scl_q & sda_q & ~sda_s;
  assign stop     = scl_s & scl_q & ~sda_q & sda_s;

  assign rx_state   = (state == ADDR) || (state == SUBH) || (state == SUBL) || (state == DATA);
  assign byte_val   = {shift[6:0], sda_s};
  assign byte_done  = rx_state && scl_rise && (bit_cnt == 3'd0);
  assign addr_match = (byte_val[7:1] == DEV_ADDR) && !byte_val[0];

  // Only a write cut short before its first data strobe is an error; once a
  // byte has been written, ending the transfer is normal.
  assign abort = (start || stop) &&
                 ((state == SUBH) || (state == ACK_SUBH) || (state == SUBL) ||
                  (state == ACK_SUBL) || ((state == DATA) && !data_written));

  always_comb begin
    state_nxt = state;
    if (start) begin
      state_nxt = ADDR;
    end else if (stop) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        ADDR:     if (byte_done) state_nxt = addr_match ? ACK_ADDR : IGNORE;
        SUBH:     if (byte_done) state_nxt = ACK_SUBH;
        SUBL:     if (byte_done) state_nxt = ACK_SUBL;
        DATA:     if (byte_done) state_nxt = ACK_DATA;
        ACK_ADDR: if (scl_fall && ack_on) state_nxt = SUBH;
        ACK_SUBH: if (scl_fall && ack_on) state_nxt = SUBL;
        ACK_SUBL: if (scl_fall && ack_on) state_nxt = DATA;
        ACK_DATA: begin
          if (scl_fall && ack_on) begin
`ifdef I2C_AUTOINC_EN
            state_nxt = DATA;
`else
            state_nxt = IGNORE;
`endif
          end
        end
        default:  state_nxt = state;
      endcase
    end
  end

  always_ff @(posedge I2C_clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge I2C_clk) begin
    if (reset) begin
      // idle bus level, so releasing reset cannot fake an edge
      scl_sync <= '1;
      sda_sync <= '1;
      scl_q    <= 1'b1;
      sda_q    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], bus.scl_in};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], bus.sda_in};
      scl_q    <= scl_s;
      sda_q    <= sda_s;
    end
  end

  always_ff @(posedge I2C_clk) begin
    if (reset) begin
      bit_cnt       <= 3'd7;
      shift         <= 8'h00;
      ack_on        <= 1'b0;
      data_written  <= 1'b0;
      bus.sda_oe    <= 1'b0;
      bus.wr_strobe <= 1'b0;
      bus.wr_addr   <= 16'h0000;
      bus.wr_data   <= 8'h00;
      bus.busy      <= 1'b0;
      bus.errory    <= 1'b0;
    end else begin
      bus.wr_strobe <= 1'b0;
      bus.errory    <= 1'b0;
      if (start || stop) begin
        bit_cnt      <= 3'd7;
        ack_on       <= 1'b0;
        data_written <= 1'b0;
        bus.sda_oe   <= 1'b0;
        bus.busy     <= 1'b0;
        bus.errory   <= abort;
      end else begin
        // counter wraps 0 -> 7, so it is ready for the next byte after ACK
        if (rx_state && scl_rise) begin
          shift   <= byte_val;
          bit_cnt <= bit_cnt - 3'd1;
        end
        case (state)
          ADDR: if (byte_done && addr_match) bus.busy <= 1'b1;
          SUBH: if (byte_done) bus.wr_addr[15:8] <= byte_val;
          SUBL: if (byte_done) bus.wr_addr[7:0]  <= byte_val;
          DATA: begin
            if (byte_done) begin
              bus.wr_data   <= byte_val;
              bus.wr_strobe <= 1'b1;
              data_written  <= 1'b1;
`ifdef I2C_AUTOINC_EN
              if (data_written) bus.wr_addr <= bus.wr_addr + 16'd1;
`endif
            end
          end
          ACK_ADDR, ACK_SUBH, ACK_SUBL, ACK_DATA: begin
            // first falling edge grabs SDA, second one lets it go
            if (scl_fall) begin
              ack_on     <= ~ack_on;
              bus.sda_oe <= ~ack_on;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
